// File: rtl/serial_frame_datapath_if.sv
// Control/status bundle between the ctrlD2 controller (master) and the serial frame datapath (slave).
// The controller drives sin and the enables; the datapath returns its status flags and payload.
interface serial_frame_datapath_if #(
   parameter int DATA_W = 8
);
   logic              sin;
   logic              set_8;
   logic              en_det;
   logic              en_cnt_8;
   logic              ld_down;
   logic              en_downcnt;
   logic              out_det;
   logic              out_cnt_8;
   logic              out_downcnt;
   logic [DATA_W-1:0] payload;
   logic              active;

   modport master (
      output sin, set_8, en_det, en_cnt_8, ld_down, en_downcnt,
      input  out_det, out_cnt_8, out_downcnt, payload, active
   );

   modport slave (
      input  sin, set_8, en_det, en_cnt_8, ld_down, en_downcnt,
      output out_det, out_cnt_8, out_downcnt, payload, active
   );
endinterface

// File: rtl/serial_frame_datapath.sv
// Serial frame datapath: start-pattern detector, payload shifter with bit counter, and payload down counter.
// Every state element is cleared at once by the asynchronous active-high reset.
module serial_frame_datapath #(
   parameter logic [3:0] PATTERN = 4'b1101,
   parameter int         DATA_W  = 8
) (
   input logic                   clk,
   input logic                   rst,
   serial_frame_datapath_if.slave bus
);

   localparam int                PLEN     = $bits(PATTERN);
   localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_state_t;

   det_state_t        det_q, det_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] payload_q, payload_d;
   logic [DATA_W-1:0] down_q, down_d;

   // Length of the longest pattern prefix that is a suffix of (matched prefix + new bit);
   // this gives overlap fallback for any PATTERN, including restarting out of the matched state.
   function automatic logic [2:0] det_next(input logic [2:0] matched, input logic bit_in);
      logic [PLEN:0] seq;
      logic [2:0]    best;
      logic          hit;
      int            k;
      best = '0;
      seq  = '0;
      k    = (int'(matched) > PLEN) ? PLEN : int'(matched);
      for (int j = 0; j < PLEN; j++) begin
         if (j < k) begin
            seq[j] = PATTERN[PLEN-1-j];
         end
      end
      seq[k] = bit_in;
      for (int len = 1; len <= PLEN; len++) begin
         if (len <= k + 1) begin
            hit = 1'b1;
            for (int i = 0; i < PLEN; i++) begin
               if (i < len) begin
                  if (seq[k+1-len+i] != PATTERN[PLEN-1-i]) begin
                     hit = 1'b0;
                  end
               end
            end
            if (hit) begin
               best = 3'(len);
            end
         end
      end
      return best;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_q     <= S0;
         cnt_q     <= '0;
         payload_q <= '0;
         down_q    <= '0;
      end else begin
         det_q     <= det_d;
         cnt_q     <= cnt_d;
         payload_q <= payload_d;
         down_q    <= down_d;
      end
   end

   // set_8 dominates both the detector and the shifter; the down counter only sees ld_down/en_downcnt.
   always_comb begin
      det_d     = det_q;
      cnt_d     = cnt_q;
      payload_d = payload_q;
      down_d    = down_q;

      if (bus.set_8 || !bus.en_det) begin
         det_d = S0;
      end else begin
         det_d = det_state_t'(det_next(det_q, bus.sin));
      end

      if (bus.set_8) begin
         cnt_d     = '0;
         payload_d = '0;
      end else if (bus.en_cnt_8) begin
         payload_d = {payload_q[DATA_W-2:0], bus.sin};
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end

      if (bus.ld_down) begin
         down_d = payload_q;
      end else if (bus.en_downcnt && (down_q != '0)) begin
         down_d = down_q - 1'b1;
      end
   end

   assign bus.out_det     = (det_q == S4);
   assign bus.out_cnt_8   = (cnt_q == CNT_LAST);
   assign bus.out_downcnt = (down_q == '0);
   assign bus.active      = (down_q != '0);
   assign bus.payload     = payload_q;

endmodule

// File: tb/tb_serial_frame_datapath.sv
// Bench for serial_frame_datapath: directed frames plus a random phase, each cycle compared against
// a sequence-level model (last-four-samples match, shift register arithmetic, saturating down count).
module tb_serial_frame_datapath;

   localparam int DATA_W = 8;

   logic clk;
   logic rst;
   int   n_asserts;
   int   n_fails;

   int         mdl_run;
   logic [3:0] mdl_hist;
   int         mdl_cnt;
   int         mdl_payload;
   int         mdl_down;

   serial_frame_datapath_if #(.DATA_W(DATA_W)) bus ();

   serial_frame_datapath #(
      .PATTERN(4'b1101),
      .DATA_W (DATA_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_byte(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_run     = 0;
      mdl_hist    = '0;
      mdl_cnt     = 0;
      mdl_payload = 0;
      mdl_down    = 0;
   endtask

   // Model: pattern seen iff the last four enabled samples (no break, no clear) read 1,1,0,1.
   task automatic model_step(input logic s, input logic set8, input logic endet,
                             input logic encnt, input logic ld, input logic endown);
      int old_payload;
      old_payload = mdl_payload;
      if (set8 || !endet) begin
         mdl_run  = 0;
         mdl_hist = '0;
      end else begin
         mdl_hist = {mdl_hist[2:0], s};
         mdl_run++;
      end
      if (set8) begin
         mdl_cnt     = 0;
         mdl_payload = 0;
      end else if (encnt) begin
         mdl_payload = (mdl_payload * 2 + int'(s)) % (1 << DATA_W);
         mdl_cnt     = (mdl_cnt + 1) % DATA_W;
      end
      if (ld) begin
         mdl_down = old_payload;
      end else if (endown && mdl_down > 0) begin
         mdl_down = mdl_down - 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_bit({tag, ".out_det"}, bus.out_det, (mdl_run >= 4) && (mdl_hist == 4'b1101));
      check_bit({tag, ".out_cnt_8"}, bus.out_cnt_8, mdl_cnt == DATA_W - 1);
      check_bit({tag, ".out_downcnt"}, bus.out_downcnt, mdl_down == 0);
      check_bit({tag, ".active"}, bus.active, mdl_down != 0);
      check_byte({tag, ".payload"}, bus.payload, DATA_W'(mdl_payload));
   endtask

   // Drive one cycle of controls away from the edge, clock it, then compare #1 after the edge.
   task automatic apply_stimulus(input string tag, input logic s, input logic set8, input logic endet,
                                 input logic encnt, input logic ld, input logic endown);
      bus.sin        = s;
      bus.set_8      = set8;
      bus.en_det     = endet;
      bus.en_cnt_8   = encnt;
      bus.ld_down    = ld;
      bus.en_downcnt = endown;
      @(posedge clk);
      model_step(s, set8, endet, encnt, ld, endown);
      #1;
      check_outputs(tag);
   endtask

   task automatic shift_byte(input string tag, input logic [DATA_W-1:0] value);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         apply_stimulus(tag, value[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [6:0] overlap_seq;
      logic [3:0] frame_pat;
      n_asserts = 0;
      n_fails   = 0;
      model_reset();

      rst            = 1'b1;
      bus.sin        = 1'b0;
      bus.set_8      = 1'b0;
      bus.en_det     = 1'b0;
      bus.en_cnt_8   = 1'b0;
      bus.ld_down    = 1'b0;
      bus.en_downcnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_held");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs("reset_released");

      frame_pat = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
         apply_stimulus("detect", frame_pat[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check_bit("detect_after_4th", bus.out_det, 1'b1);

      apply_stimulus("det_drop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      overlap_seq = 7'b1101101;
      for (int i = 6; i >= 0; i--) begin
         apply_stimulus("overlap", overlap_seq[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 3) check_bit("overlap_first", bus.out_det, 1'b1);
         if (i == 2) check_bit("overlap_gap", bus.out_det, 1'b0);
      end
      check_bit("overlap_second", bus.out_det, 1'b1);
      apply_stimulus("det_set8", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      shift_byte("shift_a5", 8'hA5);
      check_byte("payload_a5", bus.payload, 8'hA5);

      apply_stimulus("clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      shift_byte("shift_03", 8'h03);
      apply_stimulus("load_03", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_bit("load_03_active", bus.active, 1'b1);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus("down", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         check_bit("down_zero_flag", bus.out_downcnt, i >= 2);
      end

      apply_stimulus("set8_cnt", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_byte("set8_cnt_payload", bus.payload, 8'h00);
      apply_stimulus("load_zero", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_bit("load_zero_flag", bus.out_downcnt, 1'b1);

      for (int c = 0; c < 400; c++) begin
         apply_stimulus("random",
                        1'($urandom_range(0, 1)),
                        $urandom_range(0, 99) < 6,
                        $urandom_range(0, 99) < 85,
                        $urandom_range(0, 99) < 50,
                        $urandom_range(0, 99) < 8,
                        $urandom_range(0, 99) < 60);
      end

      apply_stimulus("frame_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      shift_byte("frame_pre", 8'h7E);
      apply_stimulus("frame_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         apply_stimulus("frame_det", frame_pat[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      apply_stimulus("frame_exit", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus("frame_up", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("mid_frame_reset");
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
